fsgn_stage: RTL and testbench
=============================

Name: fsgn_stage

Overview:
- Registered, handshaked execution stage for the FPU sign-injection family: FSGNJ, FSGNJN, FSGNJX and a raw move.
- Sits between the FPU dispatch (upstream, valid/ready) and the FP register-file writeback arbiter (downstream, valid/ready).
- Holds results in a 2-entry output buffer so that writeback stalls do not drop results.
- Keeps a sticky NaN-operand flag for the fcsr update logic.

Parameters:
- TAG_W, 5, width of the destination-register tag carried alongside each operation.
- DEPTH, 2, output buffer entries; only the value 2 is supported.

Ports:
- clk  input  1  single clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  operation offered by dispatch.
- in_ready  output  1  stage can accept an operation this cycle.
- in_op  input  2  00=SGNJ, 01=SGNJN, 10=SGNJX, 11=MOV.
- in_x1  input  32  operand rs1 (IEEE-754 single).
- in_x2  input  32  operand rs2.
- in_tag  input  TAG_W  destination tag.
- out_valid  output  1  result available at buffer head.
- out_ready  input  1  writeback consumes head.
- out_y  output  32  result.
- out_tag  output  TAG_W  tag of the result.
- out_exc  output  1  NaN-operand exception for this result.
- nan_sticky  output  1  OR of all out_exc values accepted since reset or the last clear.
- flag_clr  input  1  clears nan_sticky.

Behaviour:
- Accept: push = in_valid & in_ready. in_ready = (count != 2). It depends only on registered count, never on out_ready.
- Compute: purely combinational on the inputs. The result is written into the buffer at the push edge, so push-to-out_valid latency is 1 cycle.
- NaN test: a value is NaN when exp == 8'hFF and mantissa != 0.
- Result priority for ops 00/01/10:
  - x1 NaN -> {s1, 8'hFF, 1'b1, m1[21:0]}.
  - else x2 NaN -> {s2, 8'hFF, 1'b1, m2[21:0]}.
  - else {sgn, e1, m1}, where sgn = s2 (SGNJ), ~s2 (SGNJN), s1^s2 (SGNJX).
- Exception for ops 00/01/10: exc = x1 NaN | x2 NaN.
- MOV (11): y = x1 bit-exact, exc = 0, regardless of NaN.
- Buffer:
  - Two entries {y, tag, exc} with rd_ptr/wr_ptr (1 bit each, wrap naturally) and count (0..2).
  - pop = out_valid & out_ready.
  - count_next = count + push - pop. Simultaneous push and pop at count 1 leaves count 1, head advances.
  - out_valid = (count != 0). Outputs show the head entry; they are stable while out_valid & ~out_ready.
- Full: at count 2, in_ready = 0. A pop in that cycle only frees space for the next cycle.
- Empty: at count 0, out_valid = 0 and out_y/out_tag/out_exc show the stale head (don't-care).
- Sticky flag: nan_sticky sets on a pop with out_exc = 1.
  - flag_clr in the same cycle as a setting pop: set wins and nan_sticky = 1 next cycle.
  - flag_clr alone: nan_sticky = 0 next cycle.
- Reset (async assert, any time, including mid-stall):
  - count = 0, pointers = 0, nan_sticky = 0, buffer data = 0.
  - Outputs: out_valid = 0, in_ready = 1, out_y = 0, out_tag = 0, out_exc = 0.
  - In-flight entries are discarded.
- Deassertion is synchronised externally; the first accept is possible on the first edge after rstn rises.

Optional Feature:
- Macro FSGN_CANON_NAN_EN.
- Defined: any NaN result of ops 00/01/10 is replaced by canonical NaN 32'h7FC00000; exc is unchanged; MOV is unaffected.
- Undefined: payload/sign-preserving quiet NaN exactly as in Behaviour.

Decomposition:
- Shared fpu_pkg holds:
  - op enum sgn_op_t {SGN_J, SGN_JN, SGN_JX, SGN_MOV}.
  - Constants EXP_ALL1 = 8'hFF and CANON_NAN = 32'h7FC00000.
  - Function is_nan(logic [31:0]).
- One combinational sub-module fsgn_op_core (x1, x2, op -> y, exc) holds the datapath and the macro.
- fsgn_stage holds the handshake, buffer and sticky flag.

Test Plan:
- SGNJN 1.0 with 2.0: x1=3F800000, x2=40000000, tag=3, out_ready=1 -> next cycle out_valid=1, y=BF800000, tag=3, exc=0.
- SGNJX NaN first: x1=7FA00001, x2=BF800000 -> y=7FE00001, exc=1, nan_sticky=1 after pop. With FSGN_CANON_NAN_EN: y=7FC00000.
- MOV of NaN: x1=FF800001, op=11 -> y=FF800001, exc=0, nan_sticky unchanged.
- Backpressure:
  - out_ready=0, push SGNJ 3F800000/C0000000 then SGNJ 40400000/00000000 -> in_ready=0 after the second push; third offer held.
  - Raise out_ready -> pops BF800000 then 40400000 in order; in_ready=1 the cycle after the first pop.
- Streaming: in_valid=1 and out_ready=1 continuously for 8 ops -> one result per cycle, count stays 1, tags 0..7 in order.
- Reset mid-stall: count=2, assert rstn=0 -> out_valid=0, in_ready=1, nan_sticky=0 immediately, without waiting for a clock edge. Flag_clr coincident with a setting pop leaves nan_sticky=1.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: sign-injection op encoding, IEEE-754
// single-precision constants and the NaN classifier.
package fpu_pkg;

  typedef enum logic [1:0] {
    SGN_J   = 2'b00,
    SGN_JN  = 2'b01,
    SGN_JX  = 2'b10,
    SGN_MOV = 2'b11
  } sgn_op_t;

  localparam logic [7:0]  EXP_ALL1  = 8'hFF;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == EXP_ALL1) && (v[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fsgn_op_core.sv
// Combinational sign-injection datapath (FSGNJ/FSGNJN/FSGNJX/MOV).
// Ports: x1, x2, op in; y result, exc NaN-operand flag out.
// Macro FSGN_CANON_NAN_EN: NaN results of 00/01/10 become 7FC00000.
module fsgn_op_core
  import fpu_pkg::*;
(
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic [1:0]  op,
  output logic [31:0] y,
  output logic        exc
);

  logic n1;
  logic n2;
  logic sgn;

  assign n1 = is_nan(x1);
  assign n2 = is_nan(x2);

  always_comb begin
    sgn = x2[31];
    unique case (sgn_op_t'(op))
      SGN_J:   sgn = x2[31];
      SGN_JN:  sgn = ~x2[31];
      SGN_JX:  sgn = x1[31] ^ x2[31];
      SGN_MOV: sgn = x1[31];
      default: sgn = x2[31];
    endcase
  end

  always_comb begin
    y   = x1;
    exc = 1'b0;
    if (sgn_op_t'(op) != SGN_MOV) begin
      exc = n1 | n2;
      unique case (1'b1)
        n1:      y = {x1[31], EXP_ALL1, 1'b1, x1[21:0]};
        n2:      y = {x2[31], EXP_ALL1, 1'b1, x2[21:0]};
        default: y = {sgn, x1[30:0]};
      endcase
`ifdef FSGN_CANON_NAN_EN
      if (n1 | n2) y = CANON_NAN;
`else
`endif
    end
  end

endmodule

// File: rtl/fsgn_stage.sv
// Handshaked sign-injection stage with a 2-entry result buffer and
// sticky NaN flag. Ports: in_* from dispatch, out_* to writeback,
// nan_sticky/flag_clr for fcsr. Macro FSGN_CANON_NAN_EN (in core).
module fsgn_stage
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_exc,
  output logic             nan_sticky,
  input  logic             flag_clr
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [31:0]      y_q   [2];
  logic [TAG_W-1:0] tag_q [2];
  logic             exc_q [2];

  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;

  logic [31:0] res_y;
  logic        res_exc;
  logic        push;
  logic        pop;

  fsgn_op_core u_core (
    .x1  (in_x1),
    .x2  (in_x2),
    .op  (in_op),
    .y   (res_y),
    .exc (res_exc)
  );

  // Ready is taken from registered state only, so it never waits
  // on writeback; a pop at full frees space for the next cycle.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_y   = y_q[rd_ptr];
  assign out_tag = tag_q[rd_ptr];
  assign out_exc = exc_q[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        y_q[i]   <= '0;
        tag_q[i] <= '0;
        exc_q[i] <= 1'b0;
      end
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      nan_sticky <= 1'b0;
    end else begin
      if (push) begin
        y_q[wr_ptr]   <= res_y;
        tag_q[wr_ptr] <= in_tag;
        exc_q[wr_ptr] <= res_exc;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
      // Set beats clear when both happen together.
      if (pop && exc_q[rd_ptr]) nan_sticky <= 1'b1;
      else if (flag_clr)        nan_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fsgn_stage.sv
// Directed self-checking bench for fsgn_stage.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_fsgn_stage;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_x1;
  logic [31:0] in_x2;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [4:0]  out_tag;
  logic        out_exc;
  logic        nan_sticky;
  logic        flag_clr;

  int n_chk = 0;
  int n_err = 0;

`ifdef FSGN_CANON_NAN_EN
  localparam logic [31:0] NAN_X = 32'h7FC0_0000;
`else
  localparam logic [31:0] NAN_X = 32'h7FE0_0001;
`endif

  fsgn_stage #(.TAG_W(5), .DEPTH(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_x1      (in_x1),
    .in_x2      (in_x2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_tag    (out_tag),
    .out_exc    (out_exc),
    .nan_sticky (nan_sticky),
    .flag_clr   (flag_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic offer(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] t);
    in_valid = 1'b1;
    in_op    = op;
    in_x1    = a;
    in_x2    = b;
    in_tag   = t;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_x1     = '0;
    in_x2     = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    flag_clr  = 1'b0;
    #12;
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_ir", 32'(in_ready), 32'd1);
    check("rst_y", out_y, 32'd0);
    check("rst_st", 32'(nan_sticky), 32'd0);
    step();
    rstn = 1'b1;

    // SGNJN 1.0, 2.0
    out_ready = 1'b1;
    offer(2'b01, 32'h3F80_0000, 32'h4000_0000, 5'd3);
    step();
    in_valid = 1'b0;
    check("jn_ov", 32'(out_valid), 32'd1);
    check("jn_y", out_y, 32'hBF80_0000);
    check("jn_tag", 32'(out_tag), 32'd3);
    check("jn_exc", 32'(out_exc), 32'd0);
    step();
    check("jn_pop", 32'(out_valid), 32'd0);
    check("jn_st", 32'(nan_sticky), 32'd0);

    // SGNJX with NaN rs1
    offer(2'b10, 32'h7FA0_0001, 32'hBF80_0000, 5'd4);
    step();
    in_valid = 1'b0;
    check("jx_y", out_y, NAN_X);
    check("jx_exc", 32'(out_exc), 32'd1);
    check("jx_st0", 32'(nan_sticky), 32'd0);
    step();
    check("jx_st1", 32'(nan_sticky), 32'd1);

    // MOV of NaN: bit-exact, no exception
    offer(2'b11, 32'hFF80_0001, 32'h0, 5'd5);
    step();
    in_valid = 1'b0;
    check("mv_y", out_y, 32'hFF80_0001);
    check("mv_exc", 32'(out_exc), 32'd0);
    step();
    check("mv_st", 32'(nan_sticky), 32'd1);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    check("clr_st", 32'(nan_sticky), 32'd0);

    // Backpressure
    out_ready = 1'b0;
    offer(2'b00, 32'h3F80_0000, 32'hC000_0000, 5'd1);
    step();
    check("bp_ir1", 32'(in_ready), 32'd1);
    offer(2'b00, 32'h4040_0000, 32'h0000_0000, 5'd2);
    step();
    check("bp_ir2", 32'(in_ready), 32'd0);
    offer(2'b00, 32'h3F80_0000, 32'h0000_0000, 5'd9);
    step();
    check("bp_hold", 32'(in_ready), 32'd0);
    check("bp_hy", out_y, 32'hBF80_0000);
    check("bp_ht", 32'(out_tag), 32'd1);
    out_ready = 1'b1;
    step();
    check("bp_y2", out_y, 32'h4040_0000);
    check("bp_ir3", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_y3", out_y, 32'h3F80_0000);
    check("bp_t3", 32'(out_tag), 32'd9);
    step();
    check("bp_emp", 32'(out_valid), 32'd0);

    // Streaming: one result per cycle, count held at 1
    for (int i = 0; i < 8; i++) begin
      offer(2'b10, 32'h3F80_0000,
            {i[0], 31'd0}, 5'(i));
      step();
      check("st_ov", 32'(out_valid), 32'd1);
      check("st_ir", 32'(in_ready), 32'd1);
      check("st_tag", 32'(out_tag), 32'(i));
      check("st_y", out_y,
            {i[0], 31'h3F80_0000});
    end
    in_valid = 1'b0;
    step();
    check("st_emp", 32'(out_valid), 32'd0);

    // Reset mid-stall with sticky set
    offer(2'b00, 32'h7F80_0002, 32'h0, 5'd6);
    step();
    in_valid = 1'b0;
    step();
    check("rs_st1", 32'(nan_sticky), 32'd1);
    out_ready = 1'b0;
    offer(2'b00, 32'h3F80_0000, 32'h0, 5'd7);
    step();
    offer(2'b01, 32'h3F80_0000, 32'h0, 5'd8);
    step();
    in_valid = 1'b0;
    check("rs_full", 32'(in_ready), 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    check("rs_ov", 32'(out_valid), 32'd0);
    check("rs_ir", 32'(in_ready), 32'd1);
    check("rs_st", 32'(nan_sticky), 32'd0);
    check("rs_y", out_y, 32'd0);
    check("rs_tag", 32'(out_tag), 32'd0);
    step();
    rstn = 1'b1;

    // Clear coincident with a setting pop: set wins
    out_ready = 1'b1;
    offer(2'b00, 32'h3F80_0000, 32'hFFC0_0000, 5'd10);
    step();
    in_valid = 1'b0;
    check("cc_exc", 32'(out_exc), 32'd1);
    check("cc_y", out_y, NAN_X == 32'h7FC0_0000
          ? 32'h7FC0_0000 : 32'hFFC0_0000);
    flag_clr = 1'b1;
    step();
    check("cc_st", 32'(nan_sticky), 32'd1);
    step();
    flag_clr = 1'b0;
    check("cc_clr", 32'(nan_sticky), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
